// File: rtl/kbd_sw_io_ctrl_if.sv
// MEM-stage bus between the CPU and the KEY/SW input controller.
// The controller exposes a combinational select/read path and a registered interrupt.
interface kbd_sw_io_ctrl_if #(
  parameter int DBITS = 32
);
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wdata;
  logic             we;
  logic             re;
  logic             sel;
  logic [DBITS-1:0] rdata;
  logic             irq;

  modport master (output addr, wdata, we, re, input sel, rdata, irq);
  modport slave  (input addr, wdata, we, re, output sel, rdata, irq);
endinterface

// File: rtl/kbd_sw_io_ctrl.sv
// Memory-mapped KEY/SW input controller: 2-flop sync, per-device debounce,
// debounced data registers, sticky ready/overrun status and interrupt enable.

// One input device: synchroniser, debounce counter, data register and status bits.
module kbd_sw_dev #(
  parameter int W               = 4,
  parameter int CNTBITS         = 17,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter bit INV             = 1'b0,
  parameter bit RST_LVL         = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw,
  input  logic         rd_clr,
  input  logic         ctrl_wr,
  input  logic         wr_ie,
  input  logic         wr_ovf,
  output logic [W-1:0] data,
  output logic         ready,
  output logic         ovf,
  output logic         ie
);
  localparam logic [CNTBITS-1:0] LAST = CNTBITS'(DEBOUNCE_CYCLES - 1);

  logic [1:0][W-1:0]  sync;
  logic [W-1:0]       cand;
  logic [CNTBITS-1:0] cnt;
  logic [W-1:0]       cand_v;
  logic               evt;

  // cand stays in pin polarity so its reset value matches the synchroniser
  assign cand_v = INV ? ~cand : cand;
  assign evt    = (sync[1] == cand) && (cnt == LAST) && (cand_v != data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= {2{{W{RST_LVL}}}};
      cand  <= {W{RST_LVL}};
      cnt   <= '0;
      data  <= '0;
      ready <= 1'b0;
      ovf   <= 1'b0;
      ie    <= 1'b0;
    end else begin
      sync[0] <= raw;
      sync[1] <= sync[0];
      if (sync[1] != cand) begin
        cand <= sync[1];
        cnt  <= '0;
      end else if (cnt != LAST) begin
        cnt <= cnt + 1'b1;
      end else if (cand_v != data) begin
        data <= cand_v;
      end
      // a read landing on the commit edge consumes the old value but not the new one
      if (evt)         ready <= 1'b1;
      else if (rd_clr) ready <= 1'b0;
      if (evt && ready && !rd_clr) ovf <= 1'b1;
      else if (ctrl_wr && !wr_ovf) ovf <= 1'b0;
      if (ctrl_wr) ie <= wr_ie;
    end
  end
endmodule

module kbd_sw_io_ctrl #(
  parameter int               DBITS           = 32,
  parameter int               KEYBITS         = 4,
  parameter int               SWBITS          = 10,
  parameter int               DEBOUNCE_CYCLES = 100000,
  parameter int               CNTBITS         = 17,
  parameter logic [DBITS-1:0] ADDRKDATA       = 32'hFFFFF080,
  parameter logic [DBITS-1:0] ADDRKCTRL       = 32'hFFFFF084,
  parameter logic [DBITS-1:0] ADDRSDATA       = 32'hFFFFF090,
  parameter logic [DBITS-1:0] ADDRSCTRL       = 32'hFFFFF094
) (
  input  logic               clk,
  input  logic               RESET_N,
  input  logic [KEYBITS-1:0] key_n,
  input  logic [SWBITS-1:0]  sw,
  kbd_sw_io_ctrl_if.slave    bus
);
  logic               hit_kd, hit_kc, hit_sd, hit_sc;
  logic [KEYBITS-1:0] kdata;
  logic [SWBITS-1:0]  sdata;
  logic               kready, kovf, kie;
  logic               sready, sovf, sie;
  logic               unused_wdata;

  assign hit_kd  = (bus.addr == ADDRKDATA);
  assign hit_kc  = (bus.addr == ADDRKCTRL);
  assign hit_sd  = (bus.addr == ADDRSDATA);
  assign hit_sc  = (bus.addr == ADDRSCTRL);
  assign bus.sel = hit_kd | hit_kc | hit_sd | hit_sc;
  assign unused_wdata = ^{bus.wdata[DBITS-1:5], bus.wdata[3], bus.wdata[1:0]};

  // KEY pins are active-low; inverting after sync makes pressed read as 1
  kbd_sw_dev #(
    .W(KEYBITS), .CNTBITS(CNTBITS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .INV(1'b1), .RST_LVL(1'b1)
  ) u_key (
    .clk     (clk),
    .rst_n   (RESET_N),
    .raw     (key_n),
    .rd_clr  (bus.re && hit_kd),
    .ctrl_wr (bus.we && hit_kc),
    .wr_ie   (bus.wdata[4]),
    .wr_ovf  (bus.wdata[2]),
    .data    (kdata),
    .ready   (kready),
    .ovf     (kovf),
    .ie      (kie)
  );

  kbd_sw_dev #(
    .W(SWBITS), .CNTBITS(CNTBITS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .INV(1'b0), .RST_LVL(1'b0)
  ) u_sw (
    .clk     (clk),
    .rst_n   (RESET_N),
    .raw     (sw),
    .rd_clr  (bus.re && hit_sd),
    .ctrl_wr (bus.we && hit_sc),
    .wr_ie   (bus.wdata[4]),
    .wr_ovf  (bus.wdata[2]),
    .data    (sdata),
    .ready   (sready),
    .ovf     (sovf),
    .ie      (sie)
  );

  always_comb begin
    bus.rdata = '0;
    if (hit_kd) bus.rdata = DBITS'(kdata);
    if (hit_kc) bus.rdata = DBITS'({kie, 1'b0, kovf, 1'b0, kready});
    if (hit_sd) bus.rdata = DBITS'(sdata);
    if (hit_sc) bus.rdata = DBITS'({sie, 1'b0, sovf, 1'b0, sready});
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) bus.irq <= 1'b0;
    else          bus.irq <= (kready & kie) | (sready & sie);
  end
endmodule

// File: tb/tb_kbd_sw_io_ctrl.sv
// Directed bench for kbd_sw_io_ctrl with DEBOUNCE_CYCLES=4: expected values are
// queued when a step is driven and popped when the DUT output is sampled.
module tb_kbd_sw_io_ctrl;
  localparam logic [31:0] KD = 32'hFFFFF080;
  localparam logic [31:0] KC = 32'hFFFFF084;
  localparam logic [31:0] SD = 32'hFFFFF090;
  localparam logic [31:0] SC = 32'hFFFFF094;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key_n = 4'hF;
  logic [9:0] sw    = '0;

  kbd_sw_io_ctrl_if #(.DBITS(32)) bif ();

  kbd_sw_io_ctrl #(.DEBOUNCE_CYCLES(4), .CNTBITS(3)) dut (
    .clk     (clk),
    .RESET_N (rst_n),
    .key_n   (key_n),
    .sw      (sw),
    .bus     (bif)
  );

  always #10 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic cmp(input logic [31:0] obs);
    exp_t x;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_underflow: observed %h with nothing expected", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        n_bad++;
        $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic peek(input logic [31:0] a, input string tag, input logic [31:0] e);
    push(tag, e);
    bif.addr = a;
    bif.re   = 1'b0;
    #1;
    cmp(bif.rdata);
  endtask

  task automatic rdclr(input logic [31:0] a, input string tag, input logic [31:0] e);
    push(tag, e);
    bif.addr = a;
    bif.re   = 1'b1;
    #1;
    cmp(bif.rdata);
    @(negedge clk);
    bif.re = 1'b0;
  endtask

  task automatic sel_chk(input logic [31:0] a, input string tag, input logic e);
    push(tag, {31'b0, e});
    bif.addr = a;
    #1;
    cmp({31'b0, bif.sel});
  endtask

  task automatic irq_chk(input string tag, input logic e);
    push(tag, {31'b0, e});
    #1;
    cmp({31'b0, bif.irq});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bif.addr  = a;
    bif.wdata = d;
    bif.we    = 1'b1;
    @(negedge clk);
    bif.we    = 1'b0;
  endtask

  initial begin
    bif.addr  = '0;
    bif.wdata = '0;
    bif.we    = 1'b0;
    bif.re    = 1'b0;
    tick(2);
    rst_n = 1'b1;

    // reset state and decode
    peek(KD, "rst_kdata", 32'h0);
    peek(KC, "rst_kctrl", 32'h0);
    peek(SD, "rst_sdata", 32'h0);
    peek(SC, "rst_sctrl", 32'h0);
    irq_chk("rst_irq", 1'b0);
    tick(1);
    sel_chk(KD, "sel_kd", 1'b1);
    sel_chk(KC, "sel_kc", 1'b1);
    sel_chk(SD, "sel_sd", 1'b1);
    sel_chk(SC, "sel_sc", 1'b1);
    tick(1);
    sel_chk(32'hFFFFF088, "sel_gap", 1'b0);
    sel_chk(32'hFFFFF098, "sel_above", 1'b0);
    sel_chk(32'h0, "sel_zero", 1'b0);
    tick(1);

    // clean press commits on the 7th edge
    key_n = 4'hE;
    tick(6);
    peek(KD, "press_edge6", 32'h0);
    tick(1);
    peek(KD, "press_edge7", 32'h1);
    peek(KC, "press_kctrl", 32'h01);
    irq_chk("press_irq_masked", 1'b0);
    tick(1);

    // writes to data/unmapped addresses are ignored
    wr(KD, 32'hF);
    peek(KD, "wr_kdata_ignored", 32'h1);
    wr(32'hFFFFF088, 32'h10);
    peek(KC, "wr_unmapped_ignored", 32'h01);
    peek(32'hFFFFF088, "rdata_unmapped", 32'h0);
    tick(1);

    // bounce never commits, then a held release does
    rdclr(KD, "kdata_read", 32'h1);
    peek(KC, "kready_cleared", 32'h0);
    for (int i = 0; i < 10; i++) begin
      key_n = (i % 2 == 0) ? 4'hF : 4'hE;
      tick(2);
    end
    peek(KD, "bounce_kdata", 32'h1);
    peek(KC, "bounce_kready", 32'h0);
    key_n = 4'hF;
    tick(6);
    peek(KD, "release_edge6", 32'h1);
    tick(1);
    peek(KD, "release_edge7", 32'h0);
    peek(KC, "release_kctrl", 32'h01);
    tick(1);

    // overrun, interrupt enable and read-clear
    sw = 10'h3FF;
    tick(7);
    peek(SD, "sw_all", 32'h3FF);
    peek(SC, "sw_all_ready", 32'h01);
    sw = 10'h001;
    tick(7);
    peek(SD, "sw_one", 32'h001);
    peek(SC, "sw_overrun", 32'h05);
    irq_chk("ovf_irq_masked", 1'b0);
    wr(SC, 32'h10);
    peek(SC, "sctrl_ie", 32'h11);
    irq_chk("irq_lag", 1'b0);
    tick(1);
    irq_chk("irq_set", 1'b1);
    rdclr(SD, "ovf_sdata_read", 32'h001);
    peek(SC, "sready_cleared", 32'h10);
    irq_chk("irq_hold", 1'b1);
    tick(1);
    irq_chk("irq_clear", 1'b0);

    // read on the commit edge returns old value; ready stays, no overrun
    sw = 10'h002;
    tick(7);
    peek(SD, "sim_pre", 32'h002);
    peek(SC, "sim_pre_ready", 32'h11);
    sw = 10'h004;
    tick(6);
    rdclr(SD, "sim_old_value", 32'h002);
    peek(SD, "sim_new_value", 32'h004);
    peek(SC, "sim_ready_no_ovf", 32'h11);
    tick(1);

    // asynchronous reset mid-debounce
    sw = 10'h008;
    tick(5);
    #2;
    rst_n = 1'b0;
    peek(SD, "arst_sdata", 32'h0);
    peek(SC, "arst_sctrl", 32'h0);
    peek(KC, "arst_kctrl", 32'h0);
    irq_chk("arst_irq", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(6);
    peek(SD, "post_rst_edge6", 32'h0);
    tick(1);
    peek(SD, "post_rst_edge7", 32'h008);
    peek(SC, "post_rst_sctrl", 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
